// File: rtl/wash_pkg.sv
// Shared definitions for the washing-machine front panel: panel-state encoding and
// default timing constants.
package wash_pkg;

  localparam int unsigned DefDebounceCycles = 4;
  localparam int unsigned DefLockDelay      = 3;
  localparam int unsigned DefTempW          = 8;
  localparam int unsigned DefTempHyst       = 2;

  typedef enum logic [1:0] {
    StIdle    = 2'b00,
    StLocking = 2'b01,
    StRunning = 2'b10,
    StRelease = 2'b11
  } panel_state_e;

endpackage

// File: rtl/wash_debounce.sv
// Single-input debouncer: db follows raw once raw has differed from it for DEBOUNCE_CYCLES
// consecutive cycles; rise pulses for one cycle when db goes 0->1.
module wash_debounce
  import wash_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles
) (
  input  logic timer,
  input  logic reset,
  input  logic raw,
  output logic db,
  output logic rise
);

  localparam int unsigned CntW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYCLES - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            db_q, db_d;
  logic            rise_q, rise_d;

  always_comb begin
    cnt_d  = '0;
    db_d   = db_q;
    rise_d = 1'b0;
    if (raw != db_q) begin
      if (cnt_q == CntLast) begin
        db_d   = raw;
        rise_d = raw;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge timer or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      db_q   <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      db_q   <= db_d;
      rise_q <= rise_d;
    end
  end

  assign db   = db_q;
  assign rise = rise_q;

endmodule

// File: rtl/wash_panel_ctrl.sv
// Front-panel debounce and door-interlock FSM feeding the wash sequencer.
// Optional build macro WASH_CHILD_LOCK_EN adds a child_lock input that masks start/cancel.
module wash_panel_ctrl
  import wash_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned LOCK_DELAY      = DefLockDelay,
  parameter int unsigned TEMP_W          = DefTempW,
  parameter int unsigned TEMP_HYST       = DefTempHyst
) (
  input  logic              timer,
  input  logic              reset,
`ifdef WASH_CHILD_LOCK_EN
  input  logic              child_lock,
`endif
  input  logic              door_sw,
  input  logic              start_raw,
  input  logic              cancel_raw,
  input  logic              quiet_raw,
  input  logic [TEMP_W-1:0] temp_set,
  input  logic [TEMP_W-1:0] temp_meas,
  input  logic              unload,
  output logic              closeDoor,
  output logic              StartButton,
  output logic              tmpOk,
  output logic              quiet,
  output logic              lock_cmd,
  output logic [1:0]        panel_state
);

  localparam int unsigned LockCntW = (LOCK_DELAY > 1) ? $clog2(LOCK_DELAY) : 1;
  localparam logic [LockCntW-1:0] LockLast = LockCntW'(LOCK_DELAY - 1);

  logic door_db, door_rise_unused;
  logic start_db_unused, cancel_db_unused, quiet_db_unused;
  logic start_evt, cancel_evt, quiet_evt;
  logic start_ok, cancel_ok;

  wash_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_door (
    .timer (timer),
    .reset (reset),
    .raw   (door_sw),
    .db    (door_db),
    .rise  (door_rise_unused)
  );

  wash_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_start (
    .timer (timer),
    .reset (reset),
    .raw   (start_raw),
    .db    (start_db_unused),
    .rise  (start_evt)
  );

  wash_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_cancel (
    .timer (timer),
    .reset (reset),
    .raw   (cancel_raw),
    .db    (cancel_db_unused),
    .rise  (cancel_evt)
  );

  wash_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_quiet (
    .timer (timer),
    .reset (reset),
    .raw   (quiet_raw),
    .db    (quiet_db_unused),
    .rise  (quiet_evt)
  );

`ifdef WASH_CHILD_LOCK_EN
  assign start_ok  = start_evt & ~child_lock;
  assign cancel_ok = cancel_evt & ~child_lock;
`else
  assign start_ok  = start_evt;
  assign cancel_ok = cancel_evt;
`endif

  panel_state_e        state_q, state_d;
  logic [LockCntW-1:0] cnt_q, cnt_d;
  logic                tmp_ok_q, tmp_ok_d;
  logic                quiet_q, quiet_d;

  // LOCKING and RELEASE share the solenoid timer; it restarts from 0 on each entry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (start_ok && door_db) begin
          state_d = StLocking;
          cnt_d   = '0;
        end
      end
      StLocking: begin
        if (!door_db) begin
          state_d = StIdle;
        end else if (cnt_q == LockLast) begin
          state_d = StRunning;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRunning: begin
        if (unload || cancel_ok) begin
          state_d = StRelease;
          cnt_d   = '0;
        end
      end
      StRelease: begin
        if (cnt_q == LockLast) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Widened by one bit so temp_set - TEMP_HYST cannot wrap.
  logic [TEMP_W:0] set_ext, meas_ext, hyst_ext;
  logic            temp_hi, temp_lo;

  assign set_ext  = {1'b0, temp_set};
  assign meas_ext = {1'b0, temp_meas};
  assign hyst_ext = (TEMP_W + 1)'(TEMP_HYST);
  assign temp_hi  = meas_ext >= set_ext;
  assign temp_lo  = (set_ext >= hyst_ext) && (meas_ext < (set_ext - hyst_ext));

  always_comb begin
    tmp_ok_d = 1'b0;
    if (state_d == StRunning) begin
      if (temp_hi) begin
        tmp_ok_d = 1'b1;
      end else if (temp_lo) begin
        tmp_ok_d = 1'b0;
      end else begin
        tmp_ok_d = tmp_ok_q;
      end
    end
  end

  assign quiet_d = quiet_q ^ quiet_evt;

  always_ff @(posedge timer or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      tmp_ok_q <= 1'b0;
      quiet_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      tmp_ok_q <= tmp_ok_d;
      quiet_q  <= quiet_d;
    end
  end

  // All terms are flop outputs, so reset clears them without waiting for a clock edge.
  assign lock_cmd    = (state_q != StIdle);
  assign StartButton = (state_q == StRunning);
  assign closeDoor   = door_db | lock_cmd;
  assign tmpOk       = tmp_ok_q;
  assign quiet       = quiet_q;
  assign panel_state = state_q;

endmodule

// File: tb/tb_wash_panel_ctrl.sv
// Self-checking bench for wash_panel_ctrl against a history-window / phase-timestamp model.
module tb_wash_panel_ctrl;

  localparam int D = 4;
  localparam int L = 3;
  localparam int H = 2;

  logic       timer = 1'b0;
  logic       reset = 1'b1;
  logic       door_sw = 1'b0, start_raw = 1'b0, cancel_raw = 1'b0, quiet_raw = 1'b0;
  logic [7:0] temp_set = 8'd0, temp_meas = 8'd0;
  logic       unload = 1'b0;
  logic       closeDoor, StartButton, tmpOk, quiet, lock_cmd;
  logic [1:0] panel_state;

  wash_panel_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .LOCK_DELAY      (L),
    .TEMP_W          (8),
    .TEMP_HYST       (H)
  ) dut (
    .timer       (timer),
    .reset       (reset),
    .door_sw     (door_sw),
    .start_raw   (start_raw),
    .cancel_raw  (cancel_raw),
    .quiet_raw   (quiet_raw),
    .temp_set    (temp_set),
    .temp_meas   (temp_meas),
    .unload      (unload),
    .closeDoor   (closeDoor),
    .StartButton (StartButton),
    .tmpOk       (tmpOk),
    .quiet       (quiet),
    .lock_cmd    (lock_cmd),
    .panel_state (panel_state)
  );

  always #5 timer = ~timer;

  int checks = 0;
  int errors = 0;

  // Model: raw bit order is {quiet, cancel, start, door}.
  logic [D-1:0] m_hist [4];
  logic [3:0]   m_db, m_rise;
  int           m_phase, m_entry, m_cyc;
  logic         m_tmp, m_quiet;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) m_hist[k] = '0;
    m_db = '0; m_rise = '0; m_phase = 0; m_entry = 0; m_tmp = 1'b0; m_quiet = 1'b0;
  endtask

  task automatic model_edge(input logic [3:0] raw);
    int ph;
    logic [3:0] nr;
    m_cyc++;
    ph = m_phase;
    case (m_phase)
      0: if (m_rise[1] && m_db[0]) begin ph = 1; m_entry = m_cyc; end
      1: if (!m_db[0]) ph = 0; else if (m_cyc - m_entry == L) ph = 2;
      2: if (unload || m_rise[2]) begin ph = 3; m_entry = m_cyc; end
      default: if (m_cyc - m_entry == L) ph = 0;
    endcase
    if (m_rise[3]) m_quiet = ~m_quiet;
    if (ph == 2) begin
      if (int'(temp_meas) >= int'(temp_set)) m_tmp = 1'b1;
      else if (int'(temp_meas) < int'(temp_set) - H) m_tmp = 1'b0;
    end else begin
      m_tmp = 1'b0;
    end
    m_phase = ph;
    nr = '0;
    for (int k = 0; k < 4; k++) begin
      m_hist[k] = {m_hist[k][D-2:0], raw[k]};
      if (m_hist[k] == {D{~m_db[k]}}) begin
        m_db[k] = ~m_db[k];
        nr[k]   = m_db[k];
      end
    end
    m_rise = nr;
  endtask

  task automatic check_all();
    chk("panel_state", 32'(panel_state), 32'(m_phase));
    chk("lock_cmd", 32'(lock_cmd), 32'(m_phase != 0));
    chk("StartButton", 32'(StartButton), 32'(m_phase == 2));
    chk("closeDoor", 32'(closeDoor), 32'(m_db[0] | (m_phase != 0)));
    chk("tmpOk", 32'(tmpOk), 32'(m_tmp));
    chk("quiet", 32'(quiet), 32'(m_quiet));
  endtask

  task automatic step();
    logic [3:0] raw;
    raw = {quiet_raw, cancel_raw, start_raw, door_sw};
    @(posedge timer);
    model_edge(raw);
    #1;
    check_all();
  endtask

  initial begin
    int lat, rel, n;
    logic saw_start, saw_lock;
    logic [5:0] bounce;
    logic [7:0] tmeas [6];
    logic [7:0] tset  [6];
    logic       texp  [6];

    m_cyc = 0;
    model_reset();
    #2 reset = 1'b0;
    #10;
    check_all();
    @(negedge timer) reset = 1'b1;
    repeat (2) step();

    // A 3-cycle door pulse never debounces.
    door_sw = 1'b1; repeat (3) step();
    door_sw = 1'b0; repeat (6) step();
    chk("door_pulse", 32'(closeDoor), 32'd0);

    // Bounce 1,0,1,1,1,1: door only seen closed after the last four stable samples.
    bounce = 6'b111101;
    for (int i = 0; i < 6; i++) begin
      door_sw = bounce[i];
      step();
      if (i == 4) chk("door_bounce_early", 32'(closeDoor), 32'd0);
    end
    chk("door_bounce_set", 32'(closeDoor), 32'd1);

    // Start press: StartButton after D+L+1 cycles.
    start_raw = 1'b1; lat = 0;
    for (int i = 0; i < 4; i++) begin step(); lat++; end
    start_raw = 1'b0;
    while (!StartButton && lat < 20) begin step(); lat++; end
    chk("start_latency", 32'(lat), 32'(D + L + 1));

    // Temperature hysteresis, fixed expectations.
    tset  = '{8'd50, 8'd50, 8'd50, 8'd50, 8'd1, 8'd1};
    tmeas = '{8'd47, 8'd50, 8'd49, 8'd47, 8'd1, 8'd0};
    texp  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 6; i++) begin
      temp_set = tset[i]; temp_meas = tmeas[i];
      repeat (2) step();
      chk("tmpOk_directed", 32'(tmpOk), 32'(texp[i]));
    end

    // Random temperatures and quiet presses while running.
    for (int i = 0; i < 60; i++) begin
      temp_set  = 8'($urandom_range(0, 6));
      temp_meas = 8'($urandom_range(0, 9));
      if (i % 5 == 0) quiet_raw = ~quiet_raw;
      step();
    end
    quiet_raw = 1'b0;
    repeat (D + 1) step();

    // Cancel and unload in the same cycle.
    cancel_raw = 1'b1; repeat (D) step();
    unload = 1'b1; step();
    unload = 1'b0; cancel_raw = 1'b0;
    chk("release_entry", 32'(panel_state), 32'd3);
    chk("release_start_drop", 32'(StartButton), 32'd0);
    rel = 0;
    while (lock_cmd && rel < 10) begin step(); rel++; end
    chk("release_lock_delay", 32'(rel), 32'(L));
    chk("release_idle", 32'(panel_state), 32'd0);
    repeat (D + 1) step();

    // Door opened during LOCKING.
    saw_start = 1'b0; saw_lock = 1'b0;
    start_raw = 1'b1; step();
    door_sw = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) start_raw = 1'b0;
      step();
      saw_start |= StartButton;
      saw_lock  |= (panel_state == 2'b01);
    end
    chk("abort_locked", 32'(saw_lock), 32'd1);
    chk("abort_no_start", 32'(saw_start), 32'd0);
    chk("abort_idle", 32'(panel_state), 32'd0);
    chk("abort_unlock", 32'(lock_cmd), 32'd0);

    // Random soak.
    door_sw = 1'b1;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) door_sw = ~door_sw;
      if ($urandom_range(0, 7) == 0) start_raw = ~start_raw;
      if ($urandom_range(0, 9) == 0) cancel_raw = ~cancel_raw;
      if ($urandom_range(0, 11) == 0) quiet_raw = ~quiet_raw;
      unload = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 3) == 0) begin
        temp_set  = 8'($urandom_range(0, 8));
        temp_meas = 8'($urandom_range(0, 10));
      end
      step();
    end

    // Bring to RUNNING with quiet and tmpOk set, then reset asynchronously.
    door_sw = 1'b1; start_raw = 1'b0; cancel_raw = 1'b0; quiet_raw = 1'b0; unload = 1'b0;
    temp_set = 8'd0; temp_meas = 8'd5;
    n = 0;
    while ((panel_state != 2'b00 || n < D + 2) && n < 30) begin step(); n++; end
    if (!m_quiet) begin
      quiet_raw = 1'b1; repeat (D) step();
      quiet_raw = 1'b0; repeat (D) step();
    end
    start_raw = 1'b1; repeat (D) step();
    start_raw = 1'b0;
    n = 0;
    while (!StartButton && n < 20) begin step(); n++; end
    step();
    chk("pre_reset_start", 32'(StartButton), 32'd1);
    chk("pre_reset_tmpOk", 32'(tmpOk), 32'd1);
    chk("pre_reset_quiet", 32'(quiet), 32'd1);
    reset = 1'b0;
    #1;
    chk("async_lock", 32'(lock_cmd), 32'd0);
    chk("async_start", 32'(StartButton), 32'd0);
    chk("async_tmpOk", 32'(tmpOk), 32'd0);
    chk("async_quiet", 32'(quiet), 32'd0);
    chk("async_state", 32'(panel_state), 32'd0);
    model_reset();
    repeat (2) @(posedge timer);
    @(negedge timer) reset = 1'b1;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/wash_panel_ctrl.md
Name: wash_panel_ctrl

Overview:
Front-panel and door-interlock stage that sits directly upstream of the washing-machine sequencer. It takes raw front-panel and sensor inputs and produces the clean control levels the sequencer consumes: closeDoor, StartButton, tmpOk and quiet. It also drives the door-lock solenoid and releases the door when the sequencer signals unload.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive stable cycles a raw input needs before its debounced value changes (≥2)
LOCK_DELAY, 3, cycles the solenoid needs to engage or release (≥1)
TEMP_W, 8, width of the temperature buses
TEMP_HYST, 2, hysteresis band below setpoint for tmpOk clear

Ports:
timer  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
door_sw  in  1  raw door switch, 1 = closed
start_raw  in  1  raw start push-button
cancel_raw  in  1  raw cancel push-button
quiet_raw  in  1  raw quiet-mode push-button
temp_set  in  TEMP_W  heater setpoint, unsigned
temp_meas  in  TEMP_W  measured water temperature, unsigned
unload  in  1  from sequencer, 1 = cycle finished
closeDoor  out  1  to sequencer
StartButton  out  1  to sequencer, level held for the whole run
tmpOk  out  1  to sequencer
quiet  out  1  to sequencer
lock_cmd  out  1  door solenoid, 1 = locked
panel_state  out  2  FSM state, for debug and LEDs

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, FSM = IDLE, all counters 0, all debounced values 0. Reset mid-run drops lock_cmd immediately. This is intended as a fail-safe door release.
- Debounce, per raw input (door, start, cancel, quiet): the debounced value changes only after the raw input differs from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count. The debounced value updates on the edge where the count reaches DEBOUNCE_CYCLES.
- Edge detection: start_evt, cancel_evt and quiet_evt are one-cycle pulses on a debounced 0→1 transition.
- quiet: toggles on quiet_evt in any state.
- closeDoor = door_db OR lock_cmd (registered). While locked it is held at 1 regardless of switch glitches.
- FSM states (panel_state encoding):
  - IDLE (00): lock_cmd=0, StartButton=0. If start_evt and door_db=1, go to LOCKING, set lock_cmd=1, clear the counter. start_evt with door_db=0 is ignored.
  - LOCKING (01): the counter increments each cycle. If door_db falls, go to IDLE and set lock_cmd=0. When the counter reaches LOCK_DELAY-1, go to RUNNING and set StartButton=1.
  - RUNNING (10): StartButton=1, lock_cmd=1. unload=1 or cancel_evt sends the FSM to RELEASE. Both in the same cycle also go to RELEASE, counted once. start_evt is ignored.
  - RELEASE (11): StartButton=0 on entry, lock_cmd stays 1 for LOCK_DELAY cycles, then lock_cmd=0 and the FSM goes to IDLE. All events are ignored.
- tmpOk is registered and forced to 0 outside RUNNING. In RUNNING:
  - Set when temp_meas ≥ temp_set.
  - Clear when temp_meas < temp_set − TEMP_HYST. Compute in TEMP_W+1 bits with no underflow: if temp_set < TEMP_HYST, the clear condition is never true.
  - Otherwise hold.
- Latency: raw start to StartButton = DEBOUNCE_CYCLES + LOCK_DELAY + 1 cycles, nominal.

Optional Feature:
WASH_CHILD_LOCK_EN
- Defined: adds input child_lock (1 bit). When child_lock=1, start_evt in IDLE and cancel_evt in RUNNING are ignored. quiet_evt is still honoured, and unload still causes RELEASE.
- Undefined: no child_lock port; behaviour is exactly as above.

Decomposition:
- Shared package wash_pkg: panel-state encodings (IDLE/LOCKING/RUNNING/RELEASE), default DEBOUNCE_CYCLES, LOCK_DELAY and TEMP_HYST constants.
- One sub-module, wash_debounce (param DEBOUNCE_CYCLES; ports timer, reset, raw, db, rise), instantiated four times.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, LOCK_DELAY=3.
- Door bounce 1,0,1,1,1,1 on door_sw → closeDoor rises only after the final four stable 1s; a 3-cycle pulse never sets it.
- Door closed, start_raw held 4 cycles → panel_state 00→01, lock_cmd=1 one cycle after the debounce edge; StartButton=1 exactly 3 cycles later.
- Door opened during LOCKING → back to IDLE, lock_cmd=0, StartButton never asserted.
- RUNNING with temp_set=50: temp_meas 47→50 gives tmpOk=1; 49 holds 1; 47 clears to 0. With temp_set=1, temp_meas=0 tmpOk stays 1.
- RUNNING, unload and cancel asserted in the same cycle → RELEASE once; StartButton=0 at once; lock_cmd falls 3 cycles later; then IDLE.
- reset pulled low during RUNNING → lock_cmd, StartButton and tmpOk go to 0 asynchronously, before the next timer edge; quiet returns to 0.
